// File: rtl/branch_trace_logger_if.sv
// ---------------------------------------------------------------------------
// branch_trace_logger_if
// Bundles the resolve-side event inputs, the clear strobe, the valid/ready
// trace read port and the statistics outputs of branch_trace_logger.
//   master : the environment side (drives resolve events, clear, rd_ready)
//   slave  : the logger side (drives rd_valid/rd_data, level and statistics)
// Parameters mirror the logger: IDX_W index width, DEPTH FIFO entries,
// CNT_W statistics counter width.
// ---------------------------------------------------------------------------
interface branch_trace_logger_if #(
  parameter int IDX_W = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             resolve_valid;
  logic [IDX_W-1:0] resolve_index;
  logic             resolve_taken;
  logic             predicted_taken;
  logic             clear;
  logic             rd_valid;
  logic             rd_ready;
  logic [IDX_W+2:0] rd_data;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  modport master (
    output resolve_valid, resolve_index, resolve_taken, predicted_taken,
    output clear, rd_ready,
    input  rd_valid, rd_data, fifo_level,
    input  branch_count, mispredict_count, drop_count, overflow
  );

  modport slave (
    input  resolve_valid, resolve_index, resolve_taken, predicted_taken,
    input  clear, rd_ready,
    output rd_valid, rd_data, fifo_level,
    output branch_count, mispredict_count, drop_count, overflow
  );
endinterface

// File: rtl/branch_trace_logger.sv
// ---------------------------------------------------------------------------
// branch_trace_logger
// Captures resolved branch events from the predictor datapath into a FIFO and
// streams them out over a valid/ready read port, while keeping saturating
// branch / mispredict / drop statistics and a sticky overflow flag.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (pointers, level, statistics)
//   bus  : branch_trace_logger_if.slave
//          resolve_valid/index/taken, predicted_taken : resolved event
//          clear      : synchronous clear of counters and overflow
//          rd_valid/rd_ready/rd_data : trace read port,
//                       rd_data = {mispredict, predicted, taken, index}
//          fifo_level : occupancy 0..DEPTH
//          branch_count, mispredict_count, drop_count, overflow : statistics
//
// Optional feature macro: BRANCH_TRACE_MISPREDICT_ONLY_EN
//   defined   -> only mispredicted events are logged and counted as branches
//   undefined -> every resolved event is logged
// ---------------------------------------------------------------------------
module branch_trace_logger #(
  parameter int IDX_W = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  branch_trace_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDX_W + 3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // Storage is data only; validity comes from the pointers, so it is not reset.
  logic [EW-1:0]    r_mem [DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_overflow;

  logic             w_mis;
  logic             w_elig;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_rd_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [EW-1:0]    w_entry;

  assign w_mis = bus.predicted_taken ^ bus.resolve_taken;

`ifdef BRANCH_TRACE_MISPREDICT_ONLY_EN
  assign w_elig = bus.resolve_valid & w_mis;
`else
  assign w_elig = bus.resolve_valid;
`endif

  assign w_level    = r_wr_cnt - r_rd_cnt;
  assign w_full     = (w_level == (AW+1)'(DEPTH));
  assign w_rd_valid = (w_level != '0);
  assign w_pop      = w_rd_valid & bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_elig & (~w_full | w_pop);
  assign w_drop     = w_elig & w_full & ~w_pop;
  assign w_entry    = {w_mis, bus.predicted_taken, bus.resolve_taken,
                       bus.resolve_index};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_cnt[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_drop_cnt    <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) r_wr_cnt <= r_wr_cnt + (AW+1)'(1);
      if (w_pop)  r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
      // clear overrides any statistics update in the same cycle; the FIFO
      // push above is unaffected.
      if (bus.clear) begin
        r_branch_cnt  <= '0;
        r_mispred_cnt <= '0;
        r_drop_cnt    <= '0;
        r_overflow    <= 1'b0;
      end else begin
        r_branch_cnt  <= sat_inc(r_branch_cnt, w_elig);
        r_mispred_cnt <= sat_inc(r_mispred_cnt, bus.resolve_valid & w_mis);
        r_drop_cnt    <= sat_inc(r_drop_cnt, w_drop);
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Head entry is forced to zero when empty so reset shows rd_data = 0
  // immediately without resetting the storage array.
  assign bus.rd_valid         = w_rd_valid;
  assign bus.rd_data          = w_rd_valid ? r_mem[r_rd_cnt[AW-1:0]] : '0;
  assign bus.fifo_level       = w_level;
  assign bus.branch_count     = r_branch_cnt;
  assign bus.mispredict_count = r_mispred_cnt;
  assign bus.drop_count       = r_drop_cnt;
  assign bus.overflow         = r_overflow;
endmodule

// File: doc/branch_trace_logger.md
Name: branch_trace_logger

Overview:
- Write-side counterpart of the trace-driven predictor flow. It captures resolved branch events (index, predicted direction, actual direction) from the predictor datapath.
- Events are buffered in a FIFO and streamed out over a valid/ready read port to a host or trace dumper.
- Running branch and mispredict statistics are kept alongside the FIFO.
- Sits beside branch_pred_one_bit and observes its resolve/update interface.

Parameters:
- IDX_W, 1, width of branch index.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- resolve_valid  in  1  one resolved branch this cycle.
- resolve_index  in  IDX_W  branch index of resolved branch.
- resolve_taken  in  1  actual outcome (1 = T).
- predicted_taken  in  1  prediction that was made for this branch.
- clear  in  1  synchronous clear of counters and overflow flag; FIFO contents are kept.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts head entry.
- rd_data  out  IDX_W+3  head entry: {mispredict, predicted_taken, resolve_taken, resolve_index}.
- fifo_level  out  log2(DEPTH)+1  current occupancy.
- branch_count  out  CNT_W  logged-eligible resolved branches.
- mispredict_count  out  CNT_W  mispredicted branches.
- drop_count  out  CNT_W  entries lost to a full FIFO.
- overflow  out  1  sticky; set on first drop.

Behaviour:
- Reset (async, any time including mid-stream):
  - Pointers, fifo_level and all counters go to 0.
  - overflow = 0, rd_valid = 0, rd_data = 0.
  - Reset takes effect immediately; no partial entry survives.
- Event classification:
  - mispredict = predicted_taken XOR resolve_taken.
  - An event is eligible when resolve_valid = 1 and it passes the optional filter (see Optional Feature).
- Push:
  - An eligible event is written at wr_ptr on the clock edge.
  - It is visible on rd_valid/rd_data the next cycle (1-cycle latency).
  - rd_data is driven from the registered FIFO storage, with no combinational path from the resolve inputs.
- Pop: occurs on a clock edge with rd_valid & rd_ready. rd_ready while empty is ignored.
- Pointers: wrap modulo DEPTH. fifo_level = wr_count - rd_count, and 0 ≤ fifo_level ≤ DEPTH at all times.
- Push and pop in the same cycle:
  - Not full: both happen and the level is unchanged.
  - Full (level = DEPTH): the pop frees a slot and the push is accepted, so there is no drop.
  - Empty: only the push happens, because pop requires rd_valid, which is 0.
- Full with push and no pop:
  - The entry is discarded and FIFO contents are unchanged.
  - drop_count increments and overflow is set.
- Counters:
  - branch_count +1 per eligible event, whether or not it is dropped.
  - mispredict_count +1 per resolve_valid with mispredict = 1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- clear:
  - Zeroes all three counters and overflow.
  - If an event arrives in the same cycle as clear, clear wins and counters read 0 the next cycle; the FIFO push still happens.
- Statistics only change on resolve_valid cycles; idle cycles have no effect.

Optional Feature:
- Macro BRANCH_TRACE_MISPREDICT_ONLY_EN.
- Defined:
  - Only resolve_valid events with mispredict = 1 are eligible for the FIFO and branch_count.
  - mispredict_count behaves as without the macro.
  - Correct predictions are neither logged nor dropped.
- Undefined: every resolve_valid event is eligible.

Test Plan:
- Reset, then push idx=1 T/pred T, idx=0 N/pred T, idx=1 T/pred N → rd_data sequence 4'b0111, 4'b1100, 4'b1011; branch_count = 3, mispredict_count = 2.
- DEPTH=8, rd_ready = 0, push 10 events → fifo_level = 8, drop_count = 2, overflow = 1; drain yields the first 8 entries in order.
- Full FIFO, assert resolve_valid and rd_ready in the same cycle → level stays 8, drop_count unchanged, new entry appears last.
- Force branch_count to 16'hFFFE via 2^16-2 events (or CNT_W=4 with 15+ events) → saturates at the maximum; clear → 0 the next cycle while FIFO contents are preserved.
- Assert rst mid-stream with level = 5 → rd_valid = 0, fifo_level = 0, counters 0 without waiting for a clock edge.
- With BRANCH_TRACE_MISPREDICT_ONLY_EN defined, 4 events of which 1 is mispredicted → fifo_level = 1, branch_count = 1, mispredict_count = 1.
